// File: rtl/mem_check_pkg.sv
// Shared constants for the memory write checker.
//   State encoding : ST_IDLE, ST_RUN, ST_PASS, ST_FAIL (2-bit)
//   Fail codes     : FC_NONE=00, FC_DATA=01, FC_ADDR=10, FC_TMO=11
package mem_check_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PASS = 2'd2;
   localparam logic [1:0] ST_FAIL = 2'd3;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_DATA = 2'b01;
   localparam logic [1:0] FC_ADDR = 2'b10;
   localparam logic [1:0] FC_TMO  = 2'b11;

endpackage

// File: rtl/mem_check_table.sv
// Expected (address, data) pair storage: DEPTH entries of 2*DATA_W bits.
// Ports:
//   clk, reset       clock / async active-high reset (clears all entries)
//   we, waddr        write strobe and entry index (out-of-range ignored)
//   wr_addr, wr_data pair written on we
//   raddr            asynchronous read index
//   rd_addr, rd_data pair stored at raddr
module mem_check_table #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

   logic [DEPTH-1:0][2*DATA_W-1:0] mem_q;
   logic [DEPTH-1:0][2*DATA_W-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      // Index is compared one bit wider so non-power-of-two depths drop
      // writes past the last entry.
      if (we && ({1'b0, waddr} < DEPTH_L))
         mem_d[waddr] = {wr_addr, wr_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_q <= '0;
      else       mem_q <= mem_d;
   end

   assign {rd_addr, rd_data} = mem_q[raddr];

endmodule

// File: rtl/mem_write_checker.sv
// Watches the CPU store port and checks that an ordered list of expected
// (address, data) writes occurs within TIMEOUT run cycles.
// Ports:
//   clk, reset                       clock / async active-high reset
//   cfg_we, cfg_idx, cfg_addr/data   expected-table write (ignored in RUN)
//   start, start_count               arm a check of start_count writes
//   memwrite, aluout, writedata      observed store strobe/address/data
//   done, pass, fail                 result flags (registered)
//   fail_code, fail_idx              failure reason and entry (0 unless FAIL)
//   match_cnt, cycle_cnt             progress and elapsed RUN cycles
module mem_write_checker
   import mem_check_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000,
   parameter int STRICT  = 0,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [DATA_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              start,
   input  logic [IDX_W:0]    start_count,
   input  logic              memwrite,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] writedata,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [IDX_W:0]    match_cnt,
   output logic [31:0]       cycle_cnt
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [IDX_W:0]    match_q, match_d;
   logic [IDX_W:0]    count_q, count_d;
   logic [31:0]       cyc_q, cyc_d;
   logic [1:0]        code_q, code_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, pass_q, fail_q;
   logic [DATA_W-1:0] exp_addr, exp_data;

   mem_check_table #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .we      (cfg_we && (state_q != ST_RUN)),
      .waddr   (cfg_idx),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .raddr   (match_q[IDX_W-1:0]),
      .rd_addr (exp_addr),
      .rd_data (exp_data)
   );

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      count_d = count_q;
      cyc_d   = cyc_q;
      code_d  = code_q;
      idx_d   = idx_q;
      if (state_q == ST_RUN) begin
         if (count_q == '0) begin
            state_d = ST_PASS;
         end else begin
            if (memwrite) begin
               if (aluout == exp_addr) begin
                  if (writedata == exp_data) begin
                     match_d = match_q + 1'b1;
                     if (match_d == count_q) state_d = ST_PASS;
                  end else begin
                     state_d = ST_FAIL;
                     code_d  = FC_DATA;
                     idx_d   = match_q[IDX_W-1:0];
                  end
               end else if (STRICT != 0) begin
                  state_d = ST_FAIL;
                  code_d  = FC_ADDR;
                  idx_d   = match_q[IDX_W-1:0];
               end
            end
            // A write outcome in the last cycle wins over the timeout.
            if (state_d == ST_RUN && cyc_q == TMO_LAST) begin
               state_d = ST_FAIL;
               code_d  = FC_TMO;
            end
         end
         // Counter freezes on the exit cycle so it reports the cycle
         // in which the verdict was reached.
         if (state_d == ST_RUN && cyc_q != '1) cyc_d = cyc_q + 32'd1;
      end else if (start) begin
         state_d = ST_RUN;
         match_d = '0;
         count_d = start_count;
         cyc_d   = '0;
         code_d  = FC_NONE;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         match_q <= '0;
         count_q <= '0;
         cyc_q   <= '0;
         code_q  <= FC_NONE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         count_q <= count_d;
         cyc_q   <= cyc_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         done_q  <= (state_d == ST_PASS) || (state_d == ST_FAIL);
         pass_q  <= (state_d == ST_PASS);
         fail_q  <= (state_d == ST_FAIL);
      end
   end

   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign fail_code = code_q;
   assign fail_idx  = idx_q;
   assign match_cnt = match_q;
   assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: a lax checker (STRICT=0, TIMEOUT=10) and a strict checker
// (STRICT=1) share the config and store buses but have separate starts.
module tb_mem_write_checker;

   localparam int DW = 32;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [DW-1:0] cfg_addr, cfg_data;
   logic          start_l, start_s;
   logic [IW:0]   start_count;
   logic          memwrite;
   logic [DW-1:0] aluout, writedata;

   logic          done_l, pass_l, fail_l;
   logic [1:0]    code_l;
   logic [IW-1:0] idx_l;
   logic [IW:0]   mcnt_l;
   logic [31:0]   ccnt_l;

   logic          done_s, pass_s, fail_s;
   logic [1:0]    code_s;
   logic [IW-1:0] idx_s;
   logic [IW:0]   mcnt_s;
   logic [31:0]   ccnt_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.DATA_W(DW), .DEPTH(4), .TIMEOUT(10), .STRICT(0)) u_lax (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start_l), .start_count(start_count),
      .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
      .done(done_l), .pass(pass_l), .fail(fail_l), .fail_code(code_l),
      .fail_idx(idx_l), .match_cnt(mcnt_l), .cycle_cnt(ccnt_l)
   );

   mem_write_checker #(.DATA_W(DW), .DEPTH(4), .TIMEOUT(1000), .STRICT(1)) u_strict (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start_s), .start_count(start_count),
      .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
      .done(done_s), .pass(pass_s), .fail(fail_s), .fail_code(code_s),
      .fail_idx(idx_s), .match_cnt(mcnt_s), .cycle_cnt(ccnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [IW-1:0] i, input logic [DW-1:0] a, input logic [DW-1:0] d);
      cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic st(input logic lax, input logic [IW:0] cnt);
      start_l = lax; start_s = ~lax; start_count = cnt;
      tick();
      start_l = 1'b0; start_s = 1'b0;
   endtask

   task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
      memwrite = 1'b1; aluout = a; writedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
      start_l = 1'b0; start_s = 1'b0; start_count = '0;
      memwrite = 1'b0; aluout = '0; writedata = '0;
      tick(2);
      chk("rst_done", {31'd0, done_l}, 0);
      chk("rst_pass", {31'd0, pass_l}, 0);
      chk("rst_ccnt", ccnt_l, 0);
      chk("rst_fail_s", {31'd0, fail_s}, 0);
      reset = 1'b0;
      tick();

      // Ordered match after an ignored foreign-address write.
      cfg(0, 84, 7);
      st(1'b1, 1);
      chk("run_done", {31'd0, done_l}, 0);
      wr(80, 3);
      chk("lax_ignore", {31'd0, done_l}, 0);
      wr(84, 7);
      chk("p1_pass", {31'd0, pass_l}, 1);
      chk("p1_fail", {31'd0, fail_l}, 0);
      chk("p1_mcnt", {29'd0, mcnt_l}, 1);
      chk("p1_ccnt", ccnt_l, 1);
      chk("p1_code", {30'd0, code_l}, 0);

      // Data mismatch on the expected address.
      st(1'b1, 1);
      chk("restart_mcnt", {29'd0, mcnt_l}, 0);
      wr(84, 5);
      chk("dm_fail", {31'd0, fail_l}, 1);
      chk("dm_done", {31'd0, done_l}, 1);
      chk("dm_code", {30'd0, code_l}, 1);
      chk("dm_idx", {30'd0, idx_l}, 0);

      // Timeout with no writes.
      st(1'b1, 1);
      chk("tmo_clr_code", {30'd0, code_l}, 0);
      tick(9);
      chk("tmo_pre", {31'd0, done_l}, 0);
      chk("tmo_pre_ccnt", ccnt_l, 9);
      tick();
      chk("tmo_fail", {31'd0, fail_l}, 1);
      chk("tmo_code", {30'd0, code_l}, 3);
      chk("tmo_ccnt", ccnt_l, 9);

      // Matching write in the final cycle beats the timeout.
      st(1'b1, 1);
      tick(9);
      wr(84, 7);
      chk("tmo_win_pass", {31'd0, pass_l}, 1);
      chk("tmo_win_ccnt", ccnt_l, 9);
      chk("tmo_win_code", {30'd0, code_l}, 0);

      // Zero count passes after one RUN cycle; cfg during RUN is dropped.
      st(1'b1, 0);
      cfg_we = 1'b1; cfg_idx = 0; cfg_addr = 99; cfg_data = 99;
      chk("z_run", {31'd0, done_l}, 0);
      tick();
      cfg_we = 1'b0;
      chk("z_pass", {31'd0, pass_l}, 1);
      wr(1, 1);
      chk("idle_wr_ign", {31'd0, pass_l}, 1);
      chk("idle_wr_mcnt", {29'd0, mcnt_l}, 0);
      st(1'b1, 1);
      wr(84, 7);
      chk("tbl_kept", {31'd0, pass_l}, 1);

      // Strict: second write goes to an unexpected address.
      cfg(0, 80, 1);
      cfg(1, 84, 7);
      st(1'b0, 2);
      wr(80, 1);
      chk("s_mid", {31'd0, done_s}, 0);
      chk("s_mid_mcnt", {29'd0, mcnt_s}, 1);
      wr(88, 0);
      chk("s_fail", {31'd0, fail_s}, 1);
      chk("s_code", {30'd0, code_s}, 2);
      chk("s_idx", {30'd0, idx_s}, 1);
      chk("s_mcnt", {29'd0, mcnt_s}, 1);
      chk("s_lax_idle", {31'd0, fail_l}, 0);

      // Reset between edges mid-RUN.
      st(1'b1, 1);
      tick(3);
      chk("r_ccnt", ccnt_l, 3);
      #2 reset = 1'b1;
      #1;
      chk("r_ccnt0", ccnt_l, 0);
      chk("r_done", {31'd0, done_l}, 0);
      chk("r_s_fail", {31'd0, fail_s}, 0);
      chk("r_s_code", {30'd0, code_s}, 0);
      reset = 1'b0;
      tick();
      // Table was cleared by reset, so entry 0 now expects (0,0).
      st(1'b1, 1);
      wr(0, 0);
      chk("r_rerun_pass", {31'd0, pass_l}, 1);
      chk("r_rerun_mcnt", {29'd0, mcnt_l}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
